// File: rtl/riscv_multicycle_ctrl_pkg.sv
// riscv_ctrl_pkg: states, opcodes, datapath select encodings and fault codes for the multi-cycle RV32I controller.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_FAULT
    } ctrl_state_t;

    typedef enum logic [1:0] {
        FAULT_NONE    = 2'b00,
        FAULT_OPCODE  = 2'b01,
        FAULT_BRANCH  = 2'b10,
        FAULT_TIMEOUT = 2'b11
    } fault_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic ADR_PC     = 1'b0;
    localparam logic ADR_RESULT = 1'b1;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] imm_src;
        logic [1:0] result_src;
    } ctrl_word_t;

    function automatic logic is_mem_wait(input ctrl_state_t s);
        return s == S_FETCH || s == S_MEMREAD || s == S_MEMWRITE;
    endfunction

    function automatic logic branch_legal(input logic [2:0] f3);
        return f3 == F3_BEQ || f3 == F3_BNE;
    endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// mem_timeout_counter: counts consecutive not-ready cycles of a memory wait and flags the last tolerated one.
module mem_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic waiting,
    input  logic mem_ready,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt;
    logic          stall;

    assign stall  = waiting && !mem_ready;
    assign expire = stall && cnt == CW'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else
            cnt <= stall ? cnt + 1'b1 : '0;
    end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// riscv_multicycle_ctrl: Moore FSM sequencing the shared multi-cycle RV32I datapath with a bounded memory handshake.
// Optional performance counters are built when CTRL_PERF_EN is defined.
module riscv_multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
`ifdef CTRL_PERF_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] imm_src,
    output logic [1:0] result_src,
    output logic [1:0] fault
`ifdef CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
`endif
);

    ctrl_state_t state, state_n;
    fault_t      fault_q, fault_n;
    ctrl_word_t  cw;
    logic        expire;

    mem_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .waiting  (is_mem_wait(state)),
        .mem_ready(mem_ready),
        .expire   (expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_FETCH;
            fault_q <= FAULT_NONE;
        end else begin
            state   <= state_n;
            fault_q <= fault_n;
        end
    end

    always_comb begin
        cw      = '0;
        state_n = state;
        fault_n = fault_q;
        case (state)
            S_FETCH: begin
                cw.mem_req = 1'b1;
                cw.adr_src = ADR_PC;
                if (mem_ready) begin
                    cw.ir_write   = 1'b1;
                    cw.pc_write   = 1'b1;
                    cw.alu_src_a  = SRCA_PC;
                    cw.alu_src_b  = SRCB_FOUR;
                    cw.alu_op     = ALU_ADD;
                    cw.result_src = RES_ALU;
                    state_n       = S_DECODE;
                end else if (expire) begin
                    state_n = S_FAULT;
                    fault_n = FAULT_TIMEOUT;
                end
            end
            S_DECODE: begin
                // branch target is precomputed here so BRANCH only has to compare
                cw.alu_src_a = SRCA_OLDPC;
                cw.alu_src_b = SRCB_IMM;
                cw.alu_op    = ALU_ADD;
                cw.imm_src   = opcode == OP_JAL ? IMM_J : IMM_B;
                case (opcode)
                    OP_LOAD, OP_STORE: state_n = S_MEMADR;
                    OP_RTYPE:          state_n = S_EXECR;
                    OP_ITYPE:          state_n = S_EXECI;
                    OP_BRANCH:         state_n = S_BRANCH;
                    OP_JAL:            state_n = S_JAL;
                    default: begin
                        state_n = S_FAULT;
                        fault_n = FAULT_OPCODE;
                    end
                endcase
            end
            S_MEMADR: begin
                cw.alu_src_a = SRCA_RS1;
                cw.alu_src_b = SRCB_IMM;
                cw.alu_op    = ALU_ADD;
                cw.imm_src   = opcode == OP_STORE ? IMM_S : IMM_I;
                state_n      = opcode == OP_STORE ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                cw.mem_req    = 1'b1;
                cw.adr_src    = ADR_RESULT;
                cw.result_src = RES_ALUOUT;
                if (mem_ready) begin
                    state_n = S_MEMWB;
                end else if (expire) begin
                    state_n = S_FAULT;
                    fault_n = FAULT_TIMEOUT;
                end
            end
            S_MEMWB: begin
                cw.result_src = RES_DATA;
                cw.reg_write  = 1'b1;
                state_n       = S_FETCH;
            end
            S_MEMWRITE: begin
                cw.mem_req    = 1'b1;
                cw.mem_write  = 1'b1;
                cw.adr_src    = ADR_RESULT;
                cw.result_src = RES_ALUOUT;
                if (mem_ready) begin
                    state_n = S_FETCH;
                end else if (expire) begin
                    state_n = S_FAULT;
                    fault_n = FAULT_TIMEOUT;
                end
            end
            S_EXECR: begin
                cw.alu_src_a = SRCA_RS1;
                cw.alu_src_b = SRCB_RS2;
                cw.alu_op    = ALU_FUNCT;
                state_n      = S_ALUWB;
            end
            S_EXECI: begin
                cw.alu_src_a = SRCA_RS1;
                cw.alu_src_b = SRCB_IMM;
                cw.imm_src   = IMM_I;
                cw.alu_op    = ALU_FUNCT;
                state_n      = S_ALUWB;
            end
            S_ALUWB: begin
                cw.result_src = RES_ALUOUT;
                cw.reg_write  = 1'b1;
                state_n       = S_FETCH;
            end
            S_BRANCH: begin
                cw.alu_src_a  = SRCA_RS1;
                cw.alu_src_b  = SRCB_RS2;
                cw.alu_op     = ALU_SUB;
                cw.result_src = RES_ALUOUT;
                case (funct3)
                    F3_BEQ: begin
                        cw.pc_write = zero;
                        state_n     = S_FETCH;
                    end
                    F3_BNE: begin
                        cw.pc_write = !zero;
                        state_n     = S_FETCH;
                    end
                    default: begin
                        state_n = S_FAULT;
                        fault_n = FAULT_BRANCH;
                    end
                endcase
            end
            S_JAL: begin
                // jump to the target in ALUOut while the ALU forms the link value OldPC+4
                cw.alu_src_a  = SRCA_OLDPC;
                cw.alu_src_b  = SRCB_FOUR;
                cw.alu_op     = ALU_ADD;
                cw.result_src = RES_ALUOUT;
                cw.pc_write   = 1'b1;
                state_n       = S_ALUWB;
            end
            default: ;
        endcase
        if (rst)
            cw = '0;
    end

    assign mem_req    = cw.mem_req;
    assign mem_write  = cw.mem_write;
    assign adr_src    = cw.adr_src;
    assign ir_write   = cw.ir_write;
    assign pc_write   = cw.pc_write;
    assign reg_write  = cw.reg_write;
    assign alu_src_a  = cw.alu_src_a;
    assign alu_src_b  = cw.alu_src_b;
    assign alu_op     = cw.alu_op;
    assign imm_src    = cw.imm_src;
    assign result_src = cw.result_src;
    assign fault      = fault_q;

`ifdef CTRL_PERF_EN
    logic retire;

    assign retire = state == S_ALUWB || state == S_MEMWB ||
                    (state == S_MEMWRITE && mem_ready) ||
                    (state == S_BRANCH && branch_legal(funct3));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (state != S_FAULT)
                cycle_cnt <= cycle_cnt + 1'b1;
            if (retire)
                instret_cnt <= instret_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// tb_riscv_multicycle_ctrl: directed scenarios plus randomized instruction streams checked against a phase-plan model.
module tb_riscv_multicycle_ctrl;

    localparam int T = 4;
    localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, RR = 7'b0110011;
    localparam logic [6:0] RI = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111;

    logic       clk = 1'b0, rst = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic       zero = 1'b0, mem_ready = 1'b0;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] alu_src_a, alu_src_b, alu_op, imm_src, result_src, fault;
`ifdef CTRL_PERF_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    always #5 clk = ~clk;

    riscv_multicycle_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
        .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .imm_src(imm_src), .result_src(result_src), .fault(fault)
`ifdef CTRL_PERF_EN
        , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
    );

    typedef struct packed {
        logic mreq, mwr, adr, irw, pcw, rw;
        logic [1:0] sa, sb, op, imm, res;
    } cw_t;

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // remaining phases of an instruction after DECODE, indexed by step
    function automatic string plan(input logic [6:0] op, input int k);
        case (op)
            LD: return k == 0 ? "MEMADR" : k == 1 ? "MEMREAD" : k == 2 ? "MEMWB" : "FETCH";
            ST: return k == 0 ? "MEMADR" : k == 1 ? "MEMWRITE" : "FETCH";
            RR: return k == 0 ? "EXECR" : k == 1 ? "ALUWB" : "FETCH";
            RI: return k == 0 ? "EXECI" : k == 1 ? "ALUWB" : "FETCH";
            BR: return k == 0 ? "BRANCH" : "FETCH";
            JL: return k == 0 ? "JAL" : k == 1 ? "ALUWB" : "FETCH";
            default: return "FAULT";
        endcase
    endfunction

    function automatic cw_t exp_cw(input string p, input logic [6:0] op, input logic [2:0] f3,
                                   input logic z, input logic rdy);
        cw_t e = '0;
        if (p == "FETCH") begin
            e.mreq = 1;
            if (rdy) begin e.irw = 1; e.pcw = 1; e.sb = 2; e.res = 2; end
        end else if (p == "DECODE") begin
            e.sa = 1; e.sb = 1; e.imm = op == JL ? 2'd3 : 2'd2;
        end else if (p == "MEMADR") begin
            e.sa = 2; e.sb = 1; e.imm = op == ST ? 2'd1 : 2'd0;
        end else if (p == "MEMREAD") begin
            e.mreq = 1; e.adr = 1;
        end else if (p == "MEMWB") begin
            e.res = 1; e.rw = 1;
        end else if (p == "MEMWRITE") begin
            e.mreq = 1; e.mwr = 1; e.adr = 1;
        end else if (p == "EXECR") begin
            e.sa = 2; e.op = 2;
        end else if (p == "EXECI") begin
            e.sa = 2; e.sb = 1; e.op = 2;
        end else if (p == "ALUWB") begin
            e.rw = 1;
        end else if (p == "BRANCH") begin
            e.sa = 2; e.op = 1; e.pcw = f3 == 0 ? z : f3 == 1 ? !z : 1'b0;
        end else if (p == "JAL") begin
            e.sa = 1; e.sb = 2; e.pcw = 1;
        end
        return e;
    endfunction

    string       m_phase = "FETCH";
    logic [6:0]  m_op = '0;
    int          m_k = 0, m_wait = 0;
    logic [1:0]  m_fault = '0;
    logic [31:0] m_cycles = '0, m_instret = '0;

    always @(posedge clk or posedge rst) begin
        string nx;
        int k, w;
        logic [1:0] f;
        if (rst) begin
            m_phase <= "FETCH"; m_k <= 0; m_wait <= 0; m_fault <= '0;
            m_cycles <= '0; m_instret <= '0;
        end else begin
            nx = m_phase; k = m_k; w = 0; f = m_fault;
            if (m_phase == "FETCH" || m_phase == "MEMREAD" || m_phase == "MEMWRITE") begin
                if (!mem_ready) begin
                    if (m_wait == T - 1) begin nx = "FAULT"; f = 2'b11; end
                    else w = m_wait + 1;
                end else if (m_phase == "FETCH") nx = "DECODE";
                else begin nx = plan(m_op, k); k++; end
            end else if (m_phase == "DECODE") begin
                nx = plan(opcode, 0); k = 1; m_op <= opcode;
                if (nx == "FAULT") f = 2'b01;
            end else if (m_phase == "BRANCH") begin
                if (funct3 > 3'd1) begin nx = "FAULT"; f = 2'b10; end
                else nx = "FETCH";
            end else if (m_phase != "FAULT") begin
                nx = plan(m_op, k); k++;
            end
            if (m_phase != "FAULT") m_cycles <= m_cycles + 1;
            if (nx == "FETCH" && m_phase != "FETCH") m_instret <= m_instret + 1;
            m_phase <= nx; m_k <= k; m_wait <= w; m_fault <= f;
        end
    end

    always @(negedge clk) begin
        cw_t a, e;
        a = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
             alu_src_a, alu_src_b, alu_op, imm_src, result_src};
        e = '0;
        if (!rst) e = exp_cw(m_phase, opcode, funct3, zero, mem_ready);
        chk({"ctrl_word ", m_phase}, 32'(a), 32'(e));
        chk("fault", 32'(fault), rst ? 32'd0 : 32'(m_fault));
`ifdef CTRL_PERF_EN
        chk("cycle_cnt", cycle_cnt, rst ? 32'd0 : m_cycles);
        chk("instret_cnt", instret_cnt, rst ? 32'd0 : m_instret);
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        int stall, fhold;
        #1;
        // add: FETCH, DECODE, EXECR, ALUWB
        opcode = RR; mem_ready = 1'b1;
        do_reset();
        #1 chk("add_fetch_irw", 32'({ir_write, pc_write}), 32'd3);
        tick();
        tick(); chk("add_execr_aluop", 32'(alu_op), 32'd2);
        tick(); chk("add_aluwb_rw", 32'(reg_write), 32'd1);
        opcode = LD;
        tick(); chk("add_next_fetch", 32'(mem_req), 32'd1);
`ifdef CTRL_PERF_EN
        chk("add_instret", instret_cnt, 32'd1);
        chk("add_cycles", cycle_cnt, 32'd4);
`endif
        // lw with three stalled MEMREAD cycles
        tick();
        tick(); chk("lw_memadr_imm", 32'(imm_src), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            mem_ready = (i == 3);
            #1 chk("lw_memread_req_adr", 32'({mem_req, adr_src}), 32'd3);
        end
        tick(); chk("lw_memwb", 32'({result_src, reg_write}), 32'b011);
        // beq taken, bne not taken, illegal funct3
        opcode = BR; funct3 = 3'd0; zero = 1'b1;
        tick(); tick(); tick(); chk("beq_pcw", 32'(pc_write), 32'd1);
        funct3 = 3'd1;
        tick(); tick(); tick(); chk("bne_pcw", 32'(pc_write), 32'd0);
        funct3 = 3'd4;
        tick(); tick(); tick(); tick(); chk("bad_f3_fault", 32'(fault), 32'd2);
        repeat (5) tick();
        chk("bad_f3_stuck", 32'({fault, mem_req}), 32'b100);
        // illegal opcode
        opcode = 7'h7f; funct3 = 3'd0;
        do_reset();
        tick(); tick(); chk("illegal_op_fault", 32'(fault), 32'd1);
        repeat (20) tick();
        chk("illegal_op_quiet", 32'({fault, mem_req, ir_write, pc_write, reg_write}), 32'b010000);
        // fetch timeout, then ready on the last tolerated cycle
        mem_ready = 1'b0;
        do_reset();
        tick(); tick(); tick(); tick(); chk("timeout_fault", 32'(fault), 32'd3);
        do_reset();
        tick(); tick(); tick();
        mem_ready = 1'b1; opcode = ST;
        #1 chk("timeout_rescue_irw", 32'(ir_write), 32'd1);
        tick(); chk("timeout_rescue_fault", 32'(fault), 32'd0);
        // reset in the middle of a store
        tick(); mem_ready = 1'b0;
        tick(); chk("sw_memwrite", 32'({mem_req, mem_write}), 32'd3);
        #2 rst = 1'b1;
        #1 chk("sw_rst_drop", 32'({mem_req, mem_write}), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 chk("post_rst", 32'({fault, mem_req}), 32'b001);
`ifdef CTRL_PERF_EN
        chk("post_rst_cnt", cycle_cnt | instret_cnt, 32'd0);
`endif
        // randomized instruction streams
        stall = 0; fhold = 0;
        repeat (3000) begin
            tick();
            if (m_phase == "FAULT" && ++fhold > 3) begin
                fhold = 0;
                do_reset();
            end else if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                if (m_phase == "FETCH") begin
                    case ($urandom_range(0, 12))
                        0, 1:     opcode = LD;
                        2, 3:     opcode = ST;
                        4, 5:     opcode = RR;
                        6, 7:     opcode = RI;
                        8, 9, 10: opcode = BR;
                        11:       opcode = JL;
                        default:  opcode = $urandom_range(0, 1) ? 7'h37 : 7'h67;
                    endcase
                    funct3 = $urandom_range(0, 9) < 8 ? 3'($urandom_range(0, 1)) : 3'($urandom_range(2, 7));
                end
                zero = 1'($urandom_range(0, 1));
                if (stall > 0) begin
                    stall--;
                    mem_ready = 1'b0;
                end else if ($urandom_range(0, 39) == 0) begin
                    stall = $urandom_range(2, 5);
                    mem_ready = 1'b0;
                end else begin
                    mem_ready = $urandom_range(0, 3) != 0;
                end
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/riscv_multicycle_ctrl.md
Name: riscv_multicycle_ctrl

Overview:
Moore-style FSM that sequences the shared multi-cycle RV32I datapath: one memory port, one ALU, and the PC/IR/ALUOut/Data registers. It replaces the single-cycle opcode decode with a per-state control word. It waits on a memory ready handshake, bounds that wait with a timeout, and latches a sticky fault on illegal encodings.

Parameters:
TIMEOUT_CYCLES, 256, consecutive not-ready cycles tolerated in a memory wait state before faulting (>=2)
CNT_W, 32, width of performance counters (used only with CTRL_PERF_EN)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
opcode  input  7  IR[6:0]
funct3  input  3  IR[14:12]
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes access this cycle
mem_req  output  1  memory access request
mem_write  output  1  store (valid with mem_req)
adr_src  output  1  0=PC, 1=Result
ir_write  output  1  load IR and OldPC
pc_write  output  1  load PC from Result
reg_write  output  1  register file write
alu_src_a  output  2  00=PC, 01=OldPC, 10=rs1
alu_src_b  output  2  00=rs2, 01=Imm, 10=const 4
alu_op  output  2  00=add, 01=sub, 10=by funct
imm_src  output  2  00=I, 01=S, 10=B, 11=J
result_src  output  2  00=ALUOut, 01=Data, 10=ALU result
fault  output  2  00=none, 01=illegal opcode, 10=illegal branch funct3, 11=memory timeout
cycle_cnt  output  CNT_W  CTRL_PERF_EN only
instret_cnt  output  CNT_W  CTRL_PERF_EN only

Behaviour:
- Reset: state=FETCH, fault=00, timeout count=0, perf counters=0. While rst=1, every enable/request output is forced to 0; mux selects are 0.
- Unlisted outputs are 0 in a given state. Outputs are decoded from state, plus zero/mem_ready/opcode/funct3 where stated.
- FETCH: mem_req=1, adr_src=0. Stay until mem_ready. In the mem_ready cycle: ir_write=1, pc_write=1, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10. Next state DECODE.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (target into ALUOut). imm_src=11 if opcode=1101111, else 10.
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - other -> FAULT with fault=01
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. imm_src=00 for load, 01 for store. Next MEMREAD (load) or MEMWRITE (store).
- MEMREAD: mem_req=1, adr_src=1, result_src=00. Wait for mem_ready, then MEMWB.
- MEMWB: result_src=01, reg_write=1. Next FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1, result_src=00. Wait for mem_ready, then FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10. Next ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, imm_src=00, alu_op=10. Next ALUWB.
- ALUWB: result_src=00, reg_write=1. Next FETCH.
- BRANCH: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00.
  - funct3=000 (beq): pc_write=zero.
  - funct3=001 (bne): pc_write=!zero.
  - Next FETCH for either.
  - Other funct3: pc_write=0, next FAULT with fault=10.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1. Next ALUWB (writes OldPC+4).
- FAULT: all enables 0. fault holds its value until rst. No exit except reset.
- Timeout counter:
  - Increments each cycle in FETCH/MEMREAD/MEMWRITE with mem_ready=0.
  - Clears on mem_ready or on leaving the wait state.
  - At count=TIMEOUT_CYCLES-1 with mem_ready=0: next FAULT, fault=11.
  - mem_ready in that same cycle wins; no fault.
- Reset asserted mid-access drops mem_req immediately (asynchronous). After release the FSM restarts at FETCH.

Optional Feature:
CTRL_PERF_EN
- Defined:
  - cycle_cnt increments every cycle not in FAULT.
  - instret_cnt increments once per retiring transition: ALUWB->FETCH, MEMWB->FETCH, MEMWRITE+mem_ready->FETCH, legal BRANCH->FETCH.
  - Both wrap modulo 2^CNT_W. Both clear on rst.
- Undefined: both ports and all their logic are absent. CNT_W is unused.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - state enum ctrl_state_t
  - opcode constants (OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL)
  - localparams for the adr/alu_src_a/alu_src_b/alu_op/imm_src/result_src encodings
  - fault_t codes
- Sub-module mem_timeout_counter (parameter TIMEOUT_CYCLES; inputs waiting, mem_ready; output expire).

Test Plan:
- add x3,x1,x2 (opcode 0110011), mem_ready=1 on first fetch cycle -> FETCH,DECODE,EXECR,ALUWB; reg_write=1 in cycle 4; instret_cnt 0->1.
- lw (0000011), mem_ready low 3 cycles in MEMREAD -> mem_req=1, adr_src=1 held 4 cycles; MEMWB result_src=01, reg_write=1; total 8 cycles.
- beq with zero=1 -> pc_write=1 in BRANCH. bne with zero=1 -> pc_write=0. funct3=100 -> fault=10, FSM stuck until rst.
- opcode 1111111 -> fault=01 one cycle after DECODE; all enables 0 for 20 further cycles.
- TIMEOUT_CYCLES=4, mem_ready held 0 in FETCH -> fault=11 after 4th wait cycle. Rerun with mem_ready=1 on 4th cycle -> no fault, ir_write=1.
- Assert rst mid-MEMWRITE -> mem_req/mem_write drop same cycle. After release: FETCH, fault=00, counters=0.
